rggen_host_if_axi4lite: RTL

RGGEN_HOST_IF_AXI4LITE -- requirements
Module: rggen_host_if_axi4lite

---
 rtl/rggen_host_if_axi4lite_if.sv | 51 +++++
 rtl/rggen_host_if_axi4lite.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rggen_host_if_axi4lite_if.sv
// rtl/rggen_host_if_axi4lite_if.sv - AXI4-Lite host bus and register-block command signals
interface rggen_host_if_axi4lite_if #(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 7
);
  logic                           i_awvalid;
  logic                           o_awready;
  logic [HOST_ADDRESS_WIDTH-1:0]  i_awaddr;
  logic [2:0]                     i_awprot;
  logic                           i_wvalid;
  logic                           o_wready;
  logic [DATA_WIDTH-1:0]          i_wdata;
  logic [DATA_WIDTH/8-1:0]        i_wstrb;
  logic                           o_bvalid;
  logic                           i_bready;
  logic [1:0]                     o_bresp;
  logic                           i_arvalid;
  logic                           o_arready;
  logic [HOST_ADDRESS_WIDTH-1:0]  i_araddr;
  logic [2:0]                     i_arprot;
  logic                           o_rvalid;
  logic                           i_rready;
  logic [DATA_WIDTH-1:0]          o_rdata;
  logic [1:0]                     o_rresp;
  logic                           o_command_valid;
  logic                           o_write;
  logic                           o_read;
  logic [LOCAL_ADDRESS_WIDTH-1:0] o_address;
  logic [DATA_WIDTH-1:0]          o_write_data;
  logic [DATA_WIDTH-1:0]          o_write_mask;
  logic                           i_response_ready;
  logic [DATA_WIDTH-1:0]          i_read_data;
  logic [1:0]                     i_status;

  modport slave (
    input  i_awvalid, i_awaddr, i_awprot, i_wvalid, i_wdata, i_wstrb, i_bready,
           i_arvalid, i_araddr, i_arprot, i_rready,
           i_response_ready, i_read_data, i_status,
    output o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rdata, o_rresp,
           o_command_valid, o_write, o_read, o_address, o_write_data, o_write_mask
  );

  modport master (
    output i_awvalid, i_awaddr, i_awprot, i_wvalid, i_wdata, i_wstrb, i_bready,
           i_arvalid, i_araddr, i_arprot, i_rready,
           i_response_ready, i_read_data, i_status,
    input  o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rdata, o_rresp,
           o_command_valid, o_write, o_read, o_address, o_write_data, o_write_mask
  );
endinterface

// File: rtl/rggen_host_if_axi4lite.sv
// rtl/rggen_host_if_axi4lite.sv - AXI4-Lite to register-block bridge, one transaction at a time
// RGGEN_AXI4LITE_WRITE_PRIORITY_EN: write wins simultaneous read/write arbitration (read wins otherwise).
module rggen_host_if_axi4lite #(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 7
) (
  input logic clk,
  input logic rst,
  rggen_host_if_axi4lite_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ADDR_MASK = {LOCAL_ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

  typedef enum logic [1:0] {IDLE, COMMAND, WRITE_RESPONSE, READ_RESPONSE} state_t;

  state_t                         state;
  logic                           aw_captured;
  logic                           w_captured;
  logic [LOCAL_ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]          wdata_q;
  logic [STRB_WIDTH-1:0]          wstrb_q;

  logic idle;
  logic nothing_captured;
  logic ar_lose;
  logic w_lose;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic write_go;
  logic unused_bits;

  function automatic logic [DATA_WIDTH-1:0] expand_strobe(input logic [STRB_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      m[8*k +: 8] = {8{s[k]}};
    end
    return m;
  endfunction

  // Readies are gated by rst so they drop the moment reset is applied.
  assign idle             = (state == IDLE) && !rst;
  assign nothing_captured = !aw_captured && !w_captured;

`ifdef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
  assign ar_lose = bus.i_awvalid || bus.i_wvalid;
  assign w_lose  = 1'b0;
`else
  assign ar_lose = 1'b0;
  assign w_lose  = nothing_captured && bus.i_arvalid;
`endif

  assign bus.o_awready = idle && !aw_captured && !w_lose;
  assign bus.o_wready  = idle && !w_captured && !w_lose;
  assign bus.o_arready = idle && nothing_captured && !ar_lose;

  assign aw_hs    = bus.i_awvalid && bus.o_awready;
  assign w_hs     = bus.i_wvalid && bus.o_wready;
  assign ar_hs    = bus.i_arvalid && bus.o_arready;
  assign write_go = (aw_captured || aw_hs) && (w_captured || w_hs);

  assign unused_bits = ^{bus.i_awprot, bus.i_arprot,
                         bus.i_awaddr[HOST_ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH],
                         bus.i_araddr[HOST_ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      aw_captured         <= 1'b0;
      w_captured          <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      wstrb_q             <= '0;
      bus.o_command_valid <= 1'b0;
      bus.o_write         <= 1'b0;
      bus.o_read          <= 1'b0;
      bus.o_address       <= '0;
      bus.o_write_data    <= '0;
      bus.o_write_mask    <= '0;
      bus.o_bvalid        <= 1'b0;
      bus.o_bresp         <= '0;
      bus.o_rvalid        <= 1'b0;
      bus.o_rdata         <= '0;
      bus.o_rresp         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_captured <= 1'b1;
            addr_q      <= bus.i_awaddr[LOCAL_ADDRESS_WIDTH-1:0];
          end
          if (w_hs) begin
            w_captured <= 1'b1;
            wdata_q    <= bus.i_wdata;
            wstrb_q    <= bus.i_wstrb;
          end
          // Same-cycle captures bypass the holding registers.
          if (write_go) begin
            state               <= COMMAND;
            aw_captured         <= 1'b0;
            w_captured          <= 1'b0;
            bus.o_command_valid <= 1'b1;
            bus.o_write         <= 1'b1;
            bus.o_address       <= (aw_hs ? bus.i_awaddr[LOCAL_ADDRESS_WIDTH-1:0] : addr_q) & ADDR_MASK;
            bus.o_write_data    <= w_hs ? bus.i_wdata : wdata_q;
            bus.o_write_mask    <= expand_strobe(w_hs ? bus.i_wstrb : wstrb_q);
          end else if (ar_hs) begin
            state               <= COMMAND;
            bus.o_command_valid <= 1'b1;
            bus.o_read          <= 1'b1;
            bus.o_address       <= bus.i_araddr[LOCAL_ADDRESS_WIDTH-1:0] & ADDR_MASK;
          end
        end
        COMMAND: begin
          if (bus.i_response_ready) begin
            bus.o_command_valid <= 1'b0;
            bus.o_write         <= 1'b0;
            bus.o_read          <= 1'b0;
            bus.o_address       <= '0;
            bus.o_write_data    <= '0;
            bus.o_write_mask    <= '0;
            if (bus.o_write) begin
              state       <= WRITE_RESPONSE;
              bus.o_bvalid <= 1'b1;
              bus.o_bresp  <= bus.i_status;
            end else begin
              state       <= READ_RESPONSE;
              bus.o_rvalid <= 1'b1;
              bus.o_rdata  <= bus.i_read_data;
              bus.o_rresp  <= bus.i_status;
            end
          end
        end
        WRITE_RESPONSE: begin
          if (bus.i_bready) begin
            state        <= IDLE;
            bus.o_bvalid <= 1'b0;
            bus.o_bresp  <= '0;
          end
        end
        READ_RESPONSE: begin
          if (bus.i_rready) begin
            state        <= IDLE;
            bus.o_rvalid <= 1'b0;
            bus.o_rdata  <= '0;
            bus.o_rresp  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
